// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-back cache controller sequencing data, flag and memory RAMs.
// RAM port outputs are registered and forced idle while rst is high.
module cache_ctrl_fsm #(
    parameter int INDEX_W    = 10,
    parameter int MEM_AW     = 10,
    parameter int MEM_LAT    = 2,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    input  logic [3:0]         cpu_be,
    output logic               cpu_ack,
    output logic [31:0]        cpu_rdata,
    output logic               busy,
    output logic               cache_ena,
    output logic [15:0]        cache_wea,
    output logic [INDEX_W-1:0] cache_addra,
    output logic [127:0]       cache_dina,
    input  logic [127:0]       cache_douta,
    output logic               flag_ena,
    output logic [2:0]         flag_wea,
    output logic [INDEX_W-1:0] flag_addra,
    output logic [23:0]        flag_dina,
    input  logic [23:0]        flag_douta,
    output logic               mem_ena,
    output logic [15:0]        mem_wea,
    output logic [MEM_AW-1:0]  mem_addra,
    output logic [127:0]       mem_dina,
    input  logic [127:0]       mem_douta
);

    localparam int TAG_W = 28 - INDEX_W;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] LAT_DONE = CNT_W'(MEM_LAT);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_WBACK,
        S_REFILL,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [INDEX_W-1:0] clr_idx_q;
    logic               we_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] idx_q;
    logic [1:0]         word_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;

    logic               cache_ena_q;
    logic [15:0]        cache_wea_q;
    logic [INDEX_W-1:0] cache_addra_q;
    logic [127:0]       cache_dina_q;
    logic               flag_ena_q;
    logic [2:0]         flag_wea_q;
    logic [INDEX_W-1:0] flag_addra_q;
    logic [23:0]        flag_dina_q;
    logic               mem_ena_q;
    logic [15:0]        mem_wea_q;
    logic [MEM_AW-1:0]  mem_addra_q;
    logic [127:0]       mem_dina_q;
    logic               cpu_ack_q;
    logic [31:0]        cpu_rdata_q;

    logic [TAG_W-1:0]   vic_tag;
    logic               vic_valid;
    logic               vic_dirty;
    logic               hit;
    logic [15:0]        st_wea_d;
    logic [31:0]        rd_word_d;
    logic               unused;

    function automatic logic [23:0] flag_word(
        input logic             dirty,
        input logic [TAG_W-1:0] tag
    );
        logic [23:0] f;
        f           = '0;
        f[23]       = 1'b1;
        f[22]       = dirty;
        f[21 -: TAG_W] = tag;
        return f;
    endfunction

    assign vic_tag   = flag_douta[21 -: TAG_W];
    assign vic_valid = flag_douta[23];
    assign vic_dirty = flag_douta[22];
    assign hit       = vic_valid && (vic_tag == tag_q);
    assign st_wea_d  = 16'(be_q) << {word_q, 2'b00};
    assign rd_word_d = cache_douta[{word_q, 5'b00000} +: 32];
    assign unused    = ^{cpu_addr[1:0], flag_douta};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT_CLEAR ? S_INIT : S_IDLE;
            cnt_q         <= '0;
            clr_idx_q     <= '0;
            we_q          <= 1'b0;
            tag_q         <= '0;
            idx_q         <= '0;
            word_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            cache_ena_q   <= 1'b0;
            cache_wea_q   <= '0;
            cache_addra_q <= '0;
            cache_dina_q  <= '0;
            flag_ena_q    <= INIT_CLEAR;
            flag_wea_q    <= {3{INIT_CLEAR}};
            flag_addra_q  <= '0;
            flag_dina_q   <= '0;
            mem_ena_q     <= 1'b0;
            mem_wea_q     <= '0;
            mem_addra_q   <= '0;
            mem_dina_q    <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            cache_ena_q <= 1'b0;
            cache_wea_q <= '0;
            flag_ena_q  <= 1'b0;
            flag_wea_q  <= '0;
            mem_ena_q   <= 1'b0;
            mem_wea_q   <= '0;
            cpu_ack_q   <= 1'b0;
            unique case (state_q)
                S_INIT: begin
                    if (&clr_idx_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        clr_idx_q    <= clr_idx_q + INDEX_W'(1);
                        flag_ena_q   <= 1'b1;
                        flag_wea_q   <= 3'b111;
                        flag_addra_q <= clr_idx_q + INDEX_W'(1);
                        flag_dina_q  <= '0;
                    end
                end
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q          <= cpu_we;
                        tag_q         <= cpu_addr[31:INDEX_W+4];
                        idx_q         <= cpu_addr[INDEX_W+3:4];
                        word_q        <= cpu_addr[3:2];
                        wdata_q       <= cpu_wdata;
                        be_q          <= cpu_be;
                        cache_addra_q <= cpu_addr[INDEX_W+3:4];
                        flag_addra_q  <= cpu_addr[INDEX_W+3:4];
                        cnt_q         <= '0;
                        state_q       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    cnt_q <= '0;
                    if (hit) begin
                        if (we_q) begin
                            cache_ena_q  <= 1'b1;
                            cache_wea_q  <= st_wea_d;
                            cache_dina_q <= {4{wdata_q}};
                            flag_ena_q   <= 1'b1;
                            flag_wea_q   <= 3'b111;
                            flag_dina_q  <= flag_word(1'b1, tag_q);
                        end else begin
                            cpu_rdata_q <= rd_word_d;
                        end
                        cpu_ack_q <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (vic_valid && vic_dirty) begin
                        mem_addra_q <= MEM_AW'({vic_tag, idx_q});
                        state_q     <= S_WBACK;
                    end else begin
                        mem_addra_q <= MEM_AW'({tag_q, idx_q});
                        state_q     <= S_REFILL;
                    end
                end
                S_WBACK: begin
                    if (cnt_q == LAT_DONE) begin
                        cnt_q       <= '0;
                        mem_addra_q <= MEM_AW'({tag_q, idx_q});
                        state_q     <= S_REFILL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAT_LAST) begin
                            mem_ena_q  <= 1'b1;
                            mem_wea_q  <= 16'hffff;
                            mem_dina_q <= cache_douta;
                        end
                    end
                end
                S_REFILL: begin
                    if (cnt_q == LAT_DONE) begin
                        cnt_q   <= '0;
                        state_q <= S_LOOKUP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAT_LAST) begin
                            cache_ena_q  <= 1'b1;
                            cache_wea_q  <= 16'hffff;
                            cache_dina_q <= mem_douta;
                            flag_ena_q   <= 1'b1;
                            flag_wea_q   <= 3'b111;
                            flag_dina_q  <= flag_word(1'b0, tag_q);
                        end
                    end
                end
                S_RESP: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A write already staged for the rst cycle must never reach a RAM.
    assign cache_ena   = cache_ena_q & ~rst;
    assign cache_wea   = cache_wea_q & {16{~rst}};
    assign flag_ena    = flag_ena_q & ~rst;
    assign flag_wea    = flag_wea_q & {3{~rst}};
    assign mem_ena     = mem_ena_q & ~rst;
    assign mem_wea     = mem_wea_q & {16{~rst}};
    assign cpu_ack     = cpu_ack_q & ~rst;
    assign cache_addra = cache_addra_q;
    assign cache_dina  = cache_dina_q;
    assign flag_addra  = flag_addra_q;
    assign flag_dina   = flag_dina_q;
    assign mem_addra   = mem_addra_q;
    assign mem_dina    = mem_dina_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with behavioural RAMs and a result scoreboard.
// Runs with MEM_AW=14 so the victim and refill line addresses differ.
module tb_cache_ctrl_fsm;

    localparam int MEM_AW = 14;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cpu_req = 1'b0;
    logic               cpu_we = 1'b0;
    logic [31:0]        cpu_addr = '0;
    logic [31:0]        cpu_wdata = '0;
    logic [3:0]         cpu_be = '0;
    logic               cpu_ack;
    logic [31:0]        cpu_rdata;
    logic               busy;
    logic               cache_ena;
    logic [15:0]        cache_wea;
    logic [9:0]         cache_addra;
    logic [127:0]       cache_dina;
    logic [127:0]       cache_douta;
    logic               flag_ena;
    logic [2:0]         flag_wea;
    logic [9:0]         flag_addra;
    logic [23:0]        flag_dina;
    logic [23:0]        flag_douta;
    logic               mem_ena;
    logic [15:0]        mem_wea;
    logic [MEM_AW-1:0]  mem_addra;
    logic [127:0]       mem_dina;
    logic [127:0]       mem_douta;

    cache_ctrl_fsm #(
        .INDEX_W   (10),
        .MEM_AW    (MEM_AW),
        .MEM_LAT   (2),
        .INIT_CLEAR(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .busy       (busy),
        .cache_ena  (cache_ena),
        .cache_wea  (cache_wea),
        .cache_addra(cache_addra),
        .cache_dina (cache_dina),
        .cache_douta(cache_douta),
        .flag_ena   (flag_ena),
        .flag_wea   (flag_wea),
        .flag_addra (flag_addra),
        .flag_dina  (flag_dina),
        .flag_douta (flag_douta),
        .mem_ena    (mem_ena),
        .mem_wea    (mem_wea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_douta  (mem_douta)
    );

    always #5 clk = ~clk;

    logic [127:0] cache_ram [0:1023];
    logic [23:0]  flag_ram  [0:1023];
    logic [127:0] mem_ram   [0:(1<<MEM_AW)-1];
    bit           ram_ready = 1'b0;

    assign cache_douta = cache_ram[cache_addra];
    assign flag_douta  = flag_ram[flag_addra];
    assign mem_douta   = mem_ram[mem_addra];

    function automatic logic [127:0] line_pat(input int i);
        return {32'(i) + 32'h3000_0000, 32'(i) + 32'h2000_0000,
                32'(i) + 32'h1000_0000, 32'(i)};
    endfunction

    // Contents are loaded on the first edge, while rst still holds the DUT idle.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) begin
                cache_ram[i] <= {4{$urandom}};
                flag_ram[i]  <= 24'hc0_0000 | 24'($urandom);
            end
            for (int i = 0; i < (1 << MEM_AW); i++)
                mem_ram[i] <= line_pat(i);
            mem_ram[14'h123] <= 128'h33333333_22222222_11111111_00000000;
            ram_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 16; b++) begin
                if (cache_ena && cache_wea[b])
                    cache_ram[cache_addra][8*b +: 8] <= cache_dina[8*b +: 8];
                if (mem_ena && mem_wea[b])
                    mem_ram[mem_addra][8*b +: 8] <= mem_dina[8*b +: 8];
            end
            for (int b = 0; b < 3; b++)
                if (flag_ena && flag_wea[b])
                    flag_ram[flag_addra][8*b +: 8] <= flag_dina[8*b +: 8];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        int          lat;
        logic [31:0] rdata;
        bit          chk_rd;
    } exp_t;
    exp_t sb[$];

    int           lat_o;
    logic [31:0]  rdata_o;
    int           mem_wr_n;
    int           mem_ena_n;
    logic [MEM_AW-1:0] mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic [127:0] fill_data;
    logic [15:0]  st_wea;
    logic [23:0]  flag_last;
    logic         ack_after;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int exp_lat,
                          input logic [31:0] exp_rd, input bit chk_rd);
        exp_t e;
        e.tag = tag;
        e.lat = exp_lat;
        e.rdata = exp_rd;
        e.chk_rd = chk_rd;
        sb.push_back(e);
        mem_wr_n = 0;
        mem_ena_n = 0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        fill_data = '0;
        st_wea = '0;
        flag_last = '0;
        lat_o = -1;
        rdata_o = '0;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        cpu_be = be;
        cpu_req = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (mem_ena) mem_ena_n++;
            if (mem_ena && |mem_wea) begin
                mem_wr_n++;
                mem_wr_addr = mem_addra;
                mem_wr_data = mem_dina;
            end
            if (cache_ena && cache_wea == 16'hffff) fill_data = cache_dina;
            if (cache_ena && cache_wea != 16'hffff && |cache_wea)
                st_wea = cache_wea;
            if (flag_ena) flag_last = flag_dina;
            if (cpu_ack) begin
                lat_o = k;
                rdata_o = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        ack_after = cpu_ack;
        e = sb.pop_front();
        chk({e.tag, " latency"}, 128'(lat_o), 128'(e.lat));
        if (e.chk_rd) chk({e.tag, " rdata"}, 128'(rdata_o), 128'(e.rdata));
        chk({e.tag, " ack pulse"}, 128'(ack_after), 128'(0));
    endtask

    task automatic init_sweep(output int busy_n, output int bad_n);
        busy_n = 0;
        bad_n = 0;
        for (int k = 0; k < 1100; k++) begin
            if (!busy) break;
            if (!(flag_ena && flag_wea == 3'b111 &&
                  flag_addra == 10'(busy_n) && flag_dina == 24'h0))
                bad_n++;
            if ((cache_ena && |cache_wea) || (mem_ena && |mem_wea) || cpu_ack)
                bad_n++;
            busy_n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int bn;
        int bd;
        int rbad;
        logic [127:0] line1;
        logic [127:0] saved;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cpu_ack", 128'(cpu_ack), 128'(0));
        chk("reset cpu_rdata", 128'(cpu_rdata), 128'(0));
        chk("reset ena", 128'({cache_ena, flag_ena, mem_ena}), 128'(0));
        chk("reset wea", 128'({cache_wea, flag_wea, mem_wea}), 128'(0));
        chk("reset busy", 128'(busy), 128'(1));

        rst = 1'b0;
        #1;
        init_sweep(bn, bd);
        chk("init busy cycles", 128'(bn), 128'(1024));
        chk("init bad cycles", 128'(bd), 128'(0));
        chk("init flag 0", 128'(flag_ram[0]), 128'(0));
        chk("init flag 1023", 128'(flag_ram[1023]), 128'(0));

        do_req("cold load", 1'b0, 32'h0000_1234, '0, '0, 6, 32'h1111_1111, 1);
        chk("cold load mem writes", 128'(mem_wr_n), 128'(0));
        chk("cold load fill", fill_data,
            128'h33333333_22222222_11111111_00000000);

        do_req("hit load", 1'b0, 32'h0000_1234, '0, '0, 2, 32'h1111_1111, 1);
        chk("hit load mem_ena", 128'(mem_ena_n), 128'(0));

        do_req("hit store", 1'b1, 32'h0000_1236, 32'ha5a5_5ac3, 4'b0010,
               2, '0, 0);
        chk("hit store wea", 128'(st_wea), 128'(16'h0020));
        chk("hit store flag vd", 128'(flag_last[23:22]), 128'(2'b11));
        do_req("load merged", 1'b0, 32'h0000_1234, '0, '0, 2, 32'h1111_5a11, 1);

        line1 = line_pat(1);
        line1[31:0] = 32'hdead_beef;
        do_req("miss store", 1'b1, 32'h0000_0010, 32'hdead_beef, 4'hf,
               6, '0, 0);
        chk("miss store wea", 128'(st_wea), 128'(16'h000f));
        do_req("dirty miss", 1'b0, 32'h0000_4010, '0, '0, 9, 32'h0000_0401, 1);
        chk("wback count", 128'(mem_wr_n), 128'(1));
        chk("wback addr", 128'(mem_wr_addr), 128'(14'h001));
        chk("wback data", mem_wr_data, line1);
        chk("wback mem line", mem_ram[1], line1);
        chk("dirty refill data", fill_data, line_pat(14'h401));

        saved = cache_ram[10'h234];
        cpu_we = 1'b0;
        cpu_addr = 32'h0000_2340;
        cpu_req = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre-reset busy", 128'(busy), 128'(1));
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        rbad = 0;
        repeat (2) begin
            if ((cache_ena && |cache_wea) || (flag_ena && |flag_wea) ||
                (mem_ena && |mem_wea) || cpu_ack)
                rbad++;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        init_sweep(bn, bd);
        chk("abort rst writes", 128'(rbad), 128'(0));
        chk("abort init busy", 128'(bn), 128'(1024));
        chk("abort init bad", 128'(bd), 128'(0));
        chk("abort cache line", cache_ram[10'h234], saved);
        chk("abort flag", 128'(flag_ram[10'h234]), 128'(0));

        do_req("post abort load", 1'b0, 32'h0000_2340, '0, '0, 6,
               32'h0000_0234, 1);
        do_req("lost dirty load", 1'b0, 32'h0000_1234, '0, '0, 6,
               32'h1111_1111, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
